// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared datapath constants for the 8-bit processor
package proc_pkg;

  // Default operand width shared with the ALU.
  localparam int DATA_W = 8;

  // Operand mux selection modes.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational priority pick with a rotating start index
module rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] start,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  // Walk the requesters from start upward, wrapping by explicit compare so a
  // non power-of-two NCH never visits a nonexistent channel.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = int'(start);
    if (idx >= NCH) idx = 0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SELW'(idx);
      end
      idx = (idx == NCH - 1) ? 0 : idx + 1;
    end
  end

endmodule

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel operand mux with fixed or round-robin select
module arb_mux
  import proc_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*WIDTH-1:0]  in_data,
  output logic [NCH-1:0]        in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_chan,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [SELW-1:0]  rr_idx;
  logic             rr_vld;
  logic             fix_vld;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] gnt_data;

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (in_valid),
    .start   (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  // Fixed-mode grant: a sel beyond the last channel simply never matches.
  always_comb begin
    fix_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(sel) == i) fix_vld = in_valid[i];
    end
  end

  assign gnt_idx  = (mode == MODE_FIXED) ? sel     : rr_idx;
  assign gnt_vld  = (mode == MODE_FIXED) ? fix_vld : rr_vld;
  assign can_load = !out_valid_q || out_ready;
  assign xfer     = !rst && can_load && gnt_vld;

  // One-hot accept toward the granted producer, silent during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (xfer && int'(gnt_idx) == i) in_ready[i] = 1'b1;
    end
  end

  // Route the granted channel's word toward the output register.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(gnt_idx) == i) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and pointer next state: load wins over drain, stall holds.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_chan_d  = gnt_idx;
      if (mode == MODE_RR) begin
        rr_ptr_d = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit operand multiplexer for the 8-bit processor datapath.
- Each input channel has a valid/ready handshake.
- Selection is either fixed, driven by the `sel` input, or round-robin among the requesting channels.
- The winning word is captured in a single output register, with a valid/ready handshake toward the consumer (ALU operand bus or writeback bus).

Parameters:
- WIDTH, 8, data width of each channel in bits.
- NCH, 4, number of input channels; legal range 2 to 16.
- SELW, $clog2(NCH), width of `sel` and `out_chan`; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  NCH  per-channel request; bit i belongs to channel i.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  NCH  per-channel accept; one-hot or zero.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SELW  channel index used in fixed mode.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered selected word.
- out_chan  out  SELW  index of the channel that supplied `out_data`.
- out_ready  in  1  consumer accepts `out_data`.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. With `rst` high at a rising edge:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer rr_ptr=0.
  - `in_ready` is forced to 0 during the reset cycle.
- Load condition: can_load = !out_valid || out_ready. A held word may be replaced in the same cycle it is consumed, giving full throughput.
- Grant (combinational, from in_valid, mode, sel and rr_ptr):
  - Fixed mode: grant = sel if sel < NCH and in_valid[sel]; otherwise no grant. With sel >= NCH, no channel is ever accepted.
  - Round-robin mode: grant = first i with in_valid[i], searching from rr_ptr upward and wrapping NCH-1 to 0. No requesters means no grant.
- Ready: in_ready[g] = can_load && grant valid && (g == grant). All other bits are 0. Every in_ready bit is 0 when there is no grant.
- Transfer on channel g: in_valid[g] && in_ready[g] at a rising edge. On transfer:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - In round-robin mode only: rr_ptr <= (g+1) mod NCH. In fixed mode rr_ptr holds.
- Output handshake, no transfer this cycle:
  - If out_valid && out_ready: out_valid <= 0. out_data and out_chan hold their last values.
  - If out_valid && !out_ready: all output registers hold. This stall is the backpressure path.
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word per cycle while out_ready stays high.
- Input protocol:
  - Producers must hold in_valid and in_data stable until accepted.
  - The block does not require, or check, that producers comply.
  - Deasserting in_valid before acceptance simply drops the request.
- Mode or sel changes: take effect on the grant in the same cycle and never disturb a held output word. rr_ptr keeps its value across mode switches.
- Reset mid-stall: a held word is discarded; out_valid=0 on the next cycle.
- Starvation freedom (round-robin): a continuously valid channel is granted within NCH transfers.
- Arithmetic: the rr_ptr wrap is an explicit compare against NCH-1, not a power-of-two mask, because NCH need not be a power of two.

Decomposition:
- Package `proc_pkg`: the MODE_FIXED/MODE_RR constants and the DATA_W=8 default shared with the ALU.
- Sub-module `rr_pick`: a combinational priority search with a rotating start. Inputs are req[NCH] and start[SELW]; outputs are gnt_idx and gnt_vld. It is reusable by the future register-file write arbiter.
- The output register, can_load logic and pointer update live in arb_mux.

Test Plan (WIDTH=8, NCH=4):
1. Fixed, no stall: mode=0, sel=2, in_valid=4'b0110, ch1=8'h14, ch2=8'h0A, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=8'h0A, out_chan=2.
2. Round-robin fairness: mode=1, in_valid=4'b1111 held, data ch0..3 = 8'h00/11/22/33, out_ready=1 -> outputs 00,11,22,33,00 on consecutive cycles. rr_ptr wraps 3 to 0.
3. Backpressure: after a word 8'h55 is loaded, out_ready=0 for 3 cycles with ch1 valid -> out_data stays 8'h55, in_ready=0. When out_ready rises, ch1's word loads in that cycle and appears next cycle.
4. Skip idle channels: mode=1, rr_ptr=1, in_valid=4'b1001 -> grant ch3, then ch0 on the next transfer. out_chan sequence is 3, 0.
5. Invalid or absent select: mode=0, sel=2, in_valid=4'b1011 -> in_ready=0 and out_valid falls to 0 after the pending word is consumed. Reset with out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
